relm_i2c_master: RTL and testbench

- Byte-level I2C master controller that replaces CPU bit-banging of the i2c/gsensor pins.
- Sits on one ReLM push port (command) and one ReLM pop port (status/result) of relm_de0nano.
- Sequences START, STOP, byte WRITE and byte READ at a fixed SCL rate.
- Drives SCL push-pull and SDA open-drain, matching the existing pin wiring.

---
 rtl/relm_i2c_pkg.sv | 27 ++
 rtl/relm_i2c_tick.sv | 45 ++++
 rtl/relm_i2c_master.sv | 217 +++++++++++++++++++++
 tb/tb_relm_i2c_master.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/relm_i2c_pkg.sv
// Shared encodings for the ReLM byte-level I2C master: command codes,
// command/status field positions and the sequencer state type.
package relm_i2c_pkg;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    localparam int CMD_LSB  = 8;
    localparam int NACK_BIT = 10;
    localparam int CS_BIT   = 12;

    localparam int POP_ACK_BIT    = 8;
    localparam int POP_RVALID_BIT = 9;

    // Bits of a byte transfer are numbered 8..1 for data, 0 for the ack slot.
    localparam logic [3:0] FIRST_BIT = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_STOP,
        ST_BIT
    } state_e;

endpackage

// File: rtl/relm_i2c_tick.sv
// SCL quarter-period prescaler: emits a one-clock registered tick every DIV
// clocks while enabled; clearing restarts the count from zero.
module relm_i2c_tick #(
    parameter int DIV = 125
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [15:0] LAST = 16'(DIV - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/relm_i2c_master.sv
// Byte-level I2C master on a ReLM push/pop port pair: sequences START, STOP,
// byte WRITE and byte READ at a fixed SCL rate, one quarter-period per tick.
module relm_i2c_master
    import relm_i2c_pkg::*;
#(
    parameter int WD  = 32,
    parameter int DIV = 125
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [WD:0]   push_d,
    output logic          push_retry,
    input  logic [WD:0]   pop_d,
    output logic [WD:0]   pop_q,
    output logic          scl_out,
    output logic          sda_oe_out,
    input  logic          sda_in,
    output logic          cs_out
);

    state_e      state_q, state_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [3:0]  bit_q, bit_d;
    logic [8:0]  sh_q, sh_d;
    logic        write_q, write_d;
    logic        nack_q, nack_d;
    logic        scl_q, scl_d;
    logic        sda_oe_q, sda_oe_d;
    logic        cs_q, cs_d;
    logic        busy_q, busy_d;
    logic        rvalid_q, rvalid_d;
    logic        ack_q, ack_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        sda_meta_q, sda_sync_q;

    logic        tick;
    logic        accept;
    logic        pop_en;
    logic [1:0]  cmd;
    logic        bit_drive;
    logic        unused_bits;

    assign cmd    = push_d[CMD_LSB +: 2];
    assign accept = push_d[WD] & ~busy_q;
    assign pop_en = pop_d[WD] & ~busy_q;

    assign unused_bits = ^{push_d[WD-1:CS_BIT+1], push_d[NACK_BIT+1], pop_d[WD-1:0]};

    relm_i2c_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (accept),
        .en_i   (busy_q),
        .tick_o (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            qtr_q      <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            write_q    <= 1'b0;
            nack_q     <= 1'b0;
            scl_q      <= 1'b1;
            sda_oe_q   <= 1'b0;
            cs_q       <= 1'b1;
            busy_q     <= 1'b0;
            rvalid_q   <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            write_q    <= write_d;
            nack_q     <= nack_d;
            scl_q      <= scl_d;
            sda_oe_q   <= sda_oe_d;
            cs_q       <= cs_d;
            busy_q     <= busy_d;
            rvalid_q   <= rvalid_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            sda_meta_q <= sda_in;
            sda_sync_q <= sda_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (cmd)
                CMD_START: state_d = ST_START;
                CMD_STOP:  state_d = ST_STOP;
                CMD_WRITE: state_d = ST_BIT;
                CMD_READ:  state_d = ST_BIT;
                default:   state_d = ST_IDLE;
            endcase
        end else if (tick) begin
            case (state_q)
                ST_START: if (qtr_q == 2'd1) state_d = ST_IDLE;
                ST_STOP:  if (qtr_q == 2'd2) state_d = ST_IDLE;
                ST_BIT:   if (bit_q == 4'd0 && qtr_q == 2'd3) state_d = ST_IDLE;
                default:  state_d = state_q;
            endcase
        end
    end

    // Data bits drive the shift-register MSB on WRITE; the ack slot is
    // driven only on READ, with the latched ACK/NACK choice.
    always_comb begin
        if (bit_q != 4'd0) begin
            bit_drive = write_q ? ~sh_q[8] : 1'b0;
        end else begin
            bit_drive = write_q ? 1'b0 : ~nack_q;
        end
    end

    always_comb begin
        qtr_d    = qtr_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        write_d  = write_q;
        nack_d   = nack_q;
        scl_d    = scl_q;
        sda_oe_d = sda_oe_q;
        cs_d     = cs_q;
        busy_d   = busy_q;
        rvalid_d = rvalid_q;
        ack_d    = ack_q;
        rdata_d  = rdata_q;

        if (pop_en) begin
            rvalid_d = 1'b0;
        end

        if (accept) begin
            busy_d   = 1'b1;
            rvalid_d = 1'b0;
            qtr_d    = '0;
            bit_d    = FIRST_BIT;
            sh_d     = {push_d[7:0], 1'b0};
            write_d  = (cmd == CMD_WRITE);
            nack_d   = push_d[NACK_BIT];
            cs_d     = ~push_d[CS_BIT];
        end else if (tick) begin
            qtr_d = qtr_q + 2'd1;
            case (state_q)
                ST_START: begin
                    if (qtr_q == 2'd0) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        scl_d  = 1'b0;
                        busy_d = 1'b0;
                    end
                end
                ST_STOP: begin
                    case (qtr_q)
                        2'd0: begin
                            sda_oe_d = 1'b1;
                            scl_d    = 1'b0;
                        end
                        2'd1: scl_d = 1'b1;
                        default: begin
                            sda_oe_d = 1'b0;
                            busy_d   = 1'b0;
                        end
                    endcase
                end
                ST_BIT: begin
                    // Nine samples shift in: sh_q[8:1] end up as the byte,
                    // sh_q[0] as the ack-slot level.
                    case (qtr_q)
                        2'd0: begin
                            scl_d    = 1'b0;
                            sda_oe_d = bit_drive;
                        end
                        2'd1: scl_d = 1'b1;
                        2'd2: sh_d = {sh_q[7:0], sda_sync_q};
                        default: begin
                            scl_d = 1'b0;
                            if (bit_q == 4'd0) begin
                                busy_d   = 1'b0;
                                rvalid_d = 1'b1;
                                rdata_d  = sh_q[8:1];
                                ack_d    = write_q ? sh_q[0] : nack_q;
                            end else begin
                                bit_d = bit_q - 4'd1;
                            end
                        end
                    endcase
                end
                default: qtr_d = qtr_q;
            endcase
        end
    end

    always_comb begin
        pop_q                 = '0;
        pop_q[WD]             = busy_q;
        pop_q[POP_RVALID_BIT] = rvalid_q;
        pop_q[POP_ACK_BIT]    = ack_q;
        pop_q[7:0]            = rdata_q;
    end

    assign push_retry = busy_q;
    assign scl_out    = scl_q;
    assign sda_oe_out = sda_oe_q;
    assign cs_out     = cs_q;

endmodule

// File: tb/tb_relm_i2c_master.sv
// Bench for relm_i2c_master: timeline model of bus levels and status checked
// every cycle, an open-drain slave model, and hand-computed literal checks.
module tb_relm_i2c_master;

    localparam int WD  = 32;
    localparam int DIV = 4;

    logic          clk = 1'b0;
    logic          clkEn = 1'b0;
    logic          rst = 1'b0;
    logic [WD:0]   push_d;
    logic [WD:0]   pop_d;
    logic          push_retry;
    logic [WD:0]   pop_q;
    logic          scl_out;
    logic          sda_oe_out;
    logic          sda_in;
    logic          cs_out;

    int errors = 0;
    int checks = 0;
    logic checkEn = 1'b0;

    // Slave: 0 = idle, 1 = ack a written byte, 2 = supply a read byte
    logic [1:0] slaveMode = 2'd0;
    logic       slaveAckLow = 1'b0;
    logic [7:0] slaveByte = 8'h00;
    logic       slaveLow = 1'b0;
    logic       prevScl = 1'b1;
    int         totalRises = 0;
    int         riseBase = 0;
    int         bit0Drive = 0;
    logic       riseLog [0:15];

    // Model state
    logic       mScl, mSda, mCs, mBusy, mRvalid, mAck;
    logic [7:0] mRdata;
    logic [1:0] mCmd;
    logic [7:0] mData;
    logic       mNack;
    logic       mSclStart, mSdaStart;
    logic [7:0] mExpRdata;
    logic       mExpAck;
    int         mEdge, mAcc, mTotal;

    assign sda_in = ~(sda_oe_out | slaveLow);

    relm_i2c_master #(
        .WD  (WD),
        .DIV (DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push_d     (push_d),
        .push_retry (push_retry),
        .pop_d      (pop_d),
        .pop_q      (pop_q),
        .scl_out    (scl_out),
        .sda_oe_out (sda_oe_out),
        .sda_in     (sda_in),
        .cs_out     (cs_out)
    );

    initial begin
        forever begin
            #5;
            if (clkEn) clk = ~clk;
        end
    end

    task automatic checkOutput(input string name, input logic [WD:0] act, input logic [WD:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WD:0] cmdWord(input logic [1:0] cmd, input logic [7:0] data,
                                            input logic nack, input logic cs);
        logic [WD:0] w;
        w       = '0;
        w[WD]   = 1'b1;
        w[9:8]  = cmd;
        w[7:0]  = data;
        w[10]   = nack;
        w[12]   = cs;
        return w;
    endfunction

    // Bus levels after the first m quarter-periods of the current command.
    task automatic replay(input int m);
        logic s, d;
        int   bitN, ph;
        s = mSclStart;
        d = mSdaStart;
        for (int j = 0; j < m; j++) begin
            case (mCmd)
                2'b00: if (j == 0) d = 1'b1; else s = 1'b0;
                2'b01: begin
                    if (j == 0) begin d = 1'b1; s = 1'b0; end
                    else if (j == 1) s = 1'b1;
                    else d = 1'b0;
                end
                default: begin
                    bitN = 8 - j / 4;
                    ph   = j % 4;
                    if (ph == 0) begin
                        s = 1'b0;
                        if (bitN > 0) d = (mCmd == 2'b10) ? ~mData[bitN-1] : 1'b0;
                        else          d = (mCmd == 2'b10) ? 1'b0 : ~mNack;
                    end else if (ph == 1) begin
                        s = 1'b1;
                    end else if (ph == 3) begin
                        s = 1'b0;
                    end
                end
            endcase
        end
        mScl = s;
        mSda = d;
    endtask

    // Model: commands take 2/3/36 quarters of DIV clocks, each quarter
    // taking effect one clock after its DIV-clock boundary.
    always begin
        int n, m;
        @(posedge clk or posedge rst);
        if (rst) begin
            mScl = 1'b1; mSda = 1'b0; mCs = 1'b1; mBusy = 1'b0;
            mRvalid = 1'b0; mAck = 1'b0; mRdata = 8'h00;
            mEdge = 0; mAcc = 0; mTotal = 0;
        end else begin
            mEdge++;
            if (mBusy) begin
                n = mEdge - mAcc;
                m = (n - 1) / DIV;
                if (m > mTotal) m = mTotal;
                replay(m);
                if (m == mTotal) begin
                    mBusy = 1'b0;
                    if (mCmd[1]) begin
                        mRvalid = 1'b1;
                        mRdata  = mExpRdata;
                        mAck    = mExpAck;
                    end
                end
            end else if (push_d[WD]) begin
                mBusy     = 1'b1;
                mAcc      = mEdge;
                mCmd      = push_d[9:8];
                mData     = push_d[7:0];
                mNack     = push_d[10];
                mCs       = ~push_d[12];
                mRvalid   = 1'b0;
                mSclStart = mScl;
                mSdaStart = mSda;
                mTotal    = (mCmd == 2'b00) ? 2 : (mCmd == 2'b01) ? 3 : 36;
                if (mCmd == 2'b10) begin
                    mExpRdata = mData;
                    mExpAck   = ~((slaveMode == 2'd1) && slaveAckLow);
                end else begin
                    mExpRdata = (slaveMode == 2'd2) ? slaveByte : 8'hFF;
                    mExpAck   = mNack;
                end
            end else if (pop_d[WD]) begin
                mRvalid = 1'b0;
            end
        end
    end

    always begin
        @(negedge clk);
        if (checkEn) begin
            checkOutput("scl_out", {32'b0, scl_out}, {32'b0, mScl});
            checkOutput("sda_oe_out", {32'b0, sda_oe_out}, {32'b0, mSda});
            checkOutput("cs_out", {32'b0, cs_out}, {32'b0, mCs});
            checkOutput("push_retry", {32'b0, push_retry}, {32'b0, mBusy});
            checkOutput("pop_q", pop_q, {mBusy, 22'b0, mRvalid, mAck, mRdata});
        end
    end

    // Slave changes SDA only while SCL is low, keyed on SCL rises since issue.
    always begin
        int k;
        @(negedge clk);
        if (scl_out && !prevScl) begin
            totalRises++;
            k = totalRises - riseBase;
            if (k >= 0 && k < 16) riseLog[k] = sda_in;
        end
        prevScl = scl_out;
        k = totalRises - riseBase;
        if (slaveMode == 2'd2 && k == 8 && sda_oe_out) bit0Drive++;
        if (!scl_out) begin
            case (slaveMode)
                2'd1:    slaveLow = (k == 8) && slaveAckLow;
                2'd2:    slaveLow = (k >= 0 && k < 8) ? ~slaveByte[7-k] : 1'b0;
                default: slaveLow = 1'b0;
            endcase
        end
    end

    task automatic applyStimulus(input logic [WD:0] push, input logic pop);
        push_d = push;
        pop_d  = {pop, 32'b0};
        @(posedge clk);
        @(negedge clk);
        push_d = '0;
        pop_d  = '0;
    endtask

    task automatic waitIdle(output int n, input int budget);
        n = 0;
        while (push_retry && n < budget) begin
            n++;
            @(negedge clk);
        end
        if (push_retry) checkOutput("idle_timeout", {32'b0, push_retry}, '0);
    endtask

    initial begin
        int n, d0, sdaRise, sclRise, sdaFall, cnt;
        logic [7:0] pat;
        push_d = '0;
        pop_d  = '0;
        for (int i = 0; i < 16; i++) riseLog[i] = 1'b1;

        // Reset with the clock stopped
        #3 rst = 1'b1;
        #1;
        checkOutput("rst_scl", {32'b0, scl_out}, 33'd1);
        checkOutput("rst_sda_oe", {32'b0, sda_oe_out}, 33'd0);
        checkOutput("rst_cs", {32'b0, cs_out}, 33'd1);
        checkOutput("rst_retry", {32'b0, push_retry}, 33'd0);
        checkOutput("rst_pop_q", pop_q, 33'd0);
        checkEn = 1'b1;
        clkEn   = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // START then WRITE 0xA5 with cs select, slave acks
        applyStimulus(cmdWord(2'b00, 8'h00, 1'b0, 1'b0), 1'b0);
        waitIdle(n, 100);
        checkOutput("start_busy_len", n, 33'd9);
        slaveMode = 2'd1; slaveAckLow = 1'b1; riseBase = totalRises;
        applyStimulus(cmdWord(2'b10, 8'hA5, 1'b0, 1'b1), 1'b0);
        waitIdle(n, 400);
        checkOutput("write_busy_len", n, 33'd145);
        pat = '0;
        for (int i = 1; i <= 8; i++) pat = {pat[6:0], riseLog[i]};
        checkOutput("write_sda_pattern", {25'b0, pat}, 33'hA5);
        checkOutput("write_ack_level", {32'b0, riseLog[9]}, 33'd0);
        checkOutput("write_cs", {32'b0, cs_out}, 33'd0);
        checkOutput("write_pop_lo", {23'b0, pop_q[9:0]}, 33'h2A5);

        // READ with NACK, slave supplies 0x3C
        slaveMode = 2'd2; slaveByte = 8'h3C; riseBase = totalRises; d0 = bit0Drive;
        applyStimulus(cmdWord(2'b11, 8'h00, 1'b1, 1'b1), 1'b0);
        waitIdle(n, 400);
        checkOutput("read_rdata", {25'b0, pop_q[7:0]}, 33'h3C);
        checkOutput("read_ack", {32'b0, pop_q[8]}, 33'd1);
        checkOutput("read_bit0_released", bit0Drive - d0, 33'd0);
        applyStimulus('0, 1'b1);
        checkOutput("pop_clears_rvalid", {32'b0, pop_q[9]}, 33'd0);

        // Push and pop while busy are both ignored
        slaveMode = 2'd1; slaveAckLow = 1'b1; riseBase = totalRises;
        applyStimulus(cmdWord(2'b10, 8'h5A, 1'b0, 1'b1), 1'b0);
        checkOutput("busy_retry", {32'b0, push_retry}, 33'd1);
        applyStimulus(cmdWord(2'b10, 8'h11, 1'b0, 1'b0), 1'b1);
        checkOutput("busy_pop_rvalid", {32'b0, pop_q[9]}, 33'd0);
        checkOutput("busy_cs_kept", {32'b0, cs_out}, 33'd0);
        waitIdle(n, 400);
        checkOutput("dropped_push_rdata", {25'b0, pop_q[7:0]}, 33'h5A);
        checkOutput("dropped_push_rvalid", {32'b0, pop_q[9]}, 33'd1);

        // STOP from SCL low
        slaveMode = 2'd0;
        checkOutput("stop_pre_scl", {32'b0, scl_out}, 33'd0);
        applyStimulus(cmdWord(2'b01, 8'h00, 1'b0, 1'b1), 1'b0);
        sdaRise = -1; sclRise = -1; sdaFall = -1;
        for (cnt = 1; cnt < 100; cnt++) begin
            if (sda_oe_out && sdaRise < 0) sdaRise = cnt;
            if (scl_out && sclRise < 0) sclRise = cnt;
            if (!sda_oe_out && sdaRise >= 0 && sdaFall < 0) sdaFall = cnt;
            if (!push_retry) break;
            @(negedge clk);
        end
        checkOutput("stop_busy_len", cnt - 1, 33'd13);
        checkOutput("stop_scl_gap", sclRise - sdaRise, 33'd4);
        checkOutput("stop_sda_gap", sdaFall - sclRise, 33'd4);

        // Reset in the middle of bit 5 of a WRITE
        slaveMode = 2'd1; slaveAckLow = 1'b1; riseBase = totalRises;
        applyStimulus(cmdWord(2'b10, 8'hC3, 1'b0, 1'b1), 1'b0);
        repeat (50) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_scl", {32'b0, scl_out}, 33'd1);
        checkOutput("abort_sda_oe", {32'b0, sda_oe_out}, 33'd0);
        checkOutput("abort_cs", {32'b0, cs_out}, 33'd1);
        checkOutput("abort_retry", {32'b0, push_retry}, 33'd0);
        checkOutput("abort_pop_q", pop_q, 33'd0);
        @(negedge clk);
        rst = 1'b0;
        slaveMode = 2'd0;
        @(negedge clk);
        applyStimulus(cmdWord(2'b00, 8'h00, 1'b0, 1'b0), 1'b0);
        waitIdle(n, 100);
        checkOutput("restart_busy_len", n, 33'd9);
        checkOutput("restart_scl", {32'b0, scl_out}, 33'd0);
        checkOutput("restart_sda_oe", {32'b0, sda_oe_out}, 33'd1);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete, errors=%0d", errors);
        $fatal(1, "[TB] timeout");
    end

endmodule
